neuron_mac_q44: RTL and testbench



---
 rtl/neuron_mac_q44_if.sv | 25 ++
 rtl/neuron_mac_q44.sv | 65 ++++++
 tb/tb_neuron_mac_q44.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_q44_if.sv
// neuron_mac_q44_if: start/stream/result bundle between a neuron MAC and its producer/consumer
interface neuron_mac_q44_if #(
    parameter int IN_WIDTH   = 8,
    parameter int DATA_WIDTH = 19
);
    logic                  start;
    logic [IN_WIDTH-1:0]   bias;
    logic [IN_WIDTH-1:0]   x_in;
    logic [IN_WIDTH-1:0]   w_in;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] acc_out;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sat;
    logic                  busy;
    modport master (
        output start, bias, x_in, w_in, in_valid, out_ready,
        input  in_ready, acc_out, out_valid, sat, busy
    );
    modport slave (
        input  start, bias, x_in, w_in, in_valid, out_ready,
        output in_ready, acc_out, out_valid, sat, busy
    );
endinterface

// File: rtl/neuron_mac_q44.sv
// neuron_mac_q44: sequential saturating Q3.4 x Q3.4 multiply-accumulate into a Q10.8 neuron pre-activation
module neuron_mac_q44 #(
    parameter int DATA_WIDTH = 19,
    parameter int INT_LENGTH = 10,
    parameter int IN_WIDTH   = 8,
    parameter int N_INPUTS   = 4
) (
    input logic clk,
    input logic rst,
    neuron_mac_q44_if.slave bus
);
    localparam int SH = DATA_WIDTH - INT_LENGTH - 1 - IN_WIDTH / 2;
    localparam int CW = N_INPUTS > 1 ? $clog2(N_INPUTS) : 1;
    localparam logic [DATA_WIDTH-1:0] MAXV = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] acc, acc_nx;
    logic [CW-1:0] count;
    logic sat_r, beat, last, ovf;
    logic signed [2*IN_WIDTH-1:0] prod;
    logic [DATA_WIDTH:0] sum;
    assign beat = bus.in_valid && state == ACC;
    assign last = count == CW'(N_INPUTS - 1);
    assign prod = $signed(bus.x_in) * $signed(bus.w_in);
    assign sum  = {acc[DATA_WIDTH-1], acc} + {{(DATA_WIDTH+1-2*IN_WIDTH){prod[2*IN_WIDTH-1]}}, prod};
    // Extra sign bit disagreeing with the top result bit means the sum left the representable range
    assign ovf    = sum[DATA_WIDTH] != sum[DATA_WIDTH-1];
    assign acc_nx = ovf ? (sum[DATA_WIDTH] ? MINV : MAXV) : sum[DATA_WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = ACC;
            ACC:     if (beat && last) state_nx = OUT;
            OUT:     if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus.in_ready  = state == ACC;
        bus.out_valid = state == OUT;
        bus.busy      = state != IDLE;
        bus.acc_out   = acc;
        bus.sat       = sat_r;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            count <= '0;
            sat_r <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            acc   <= {{(DATA_WIDTH-IN_WIDTH-SH){bus.bias[IN_WIDTH-1]}}, bus.bias, {SH{1'b0}}};
            count <= '0;
            sat_r <= 1'b0;
        end else if (beat) begin
            acc   <= acc_nx;
            count <= count + CW'(1);
            sat_r <= sat_r | ovf;
        end
    end
endmodule

// File: tb/tb_neuron_mac_q44.sv
// tb_neuron_mac_q44: directed and randomized checks of the neuron MAC against an integer reference model
module tb_neuron_mac_q44;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0] bias = '0, x_in = '0, w_in = '0;
    logic [7:0] xs [16];
    logic [7:0] ws [16];
    logic [6:0] pat = 7'b1001011;
    int checks = 0, errors = 0, sel = 4;
    neuron_mac_q44_if #(.IN_WIDTH(8), .DATA_WIDTH(19)) b4(), b16(), b1();
    assign {b4.start, b4.bias, b4.x_in, b4.w_in, b4.in_valid, b4.out_ready} = {start, bias, x_in, w_in, in_valid, out_ready};
    assign {b16.start, b16.bias, b16.x_in, b16.w_in, b16.in_valid, b16.out_ready} = {start, bias, x_in, w_in, in_valid, out_ready};
    assign {b1.start, b1.bias, b1.x_in, b1.w_in, b1.in_valid, b1.out_ready} = {start, bias, x_in, w_in, in_valid, out_ready};
    neuron_mac_q44 #(.N_INPUTS(4))  u4  (.clk(clk), .rst(rst), .bus(b4));
    neuron_mac_q44 #(.N_INPUTS(16)) u16 (.clk(clk), .rst(rst), .bus(b16));
    neuron_mac_q44 #(.N_INPUTS(1))  u1  (.clk(clk), .rst(rst), .bus(b1));
    logic rdy_s, ov_s, sat_s, busy_s;
    logic [18:0] acc_s;
    assign rdy_s  = sel == 16 ? b16.in_ready  : sel == 1 ? b1.in_ready  : b4.in_ready;
    assign ov_s   = sel == 16 ? b16.out_valid : sel == 1 ? b1.out_valid : b4.out_valid;
    assign sat_s  = sel == 16 ? b16.sat       : sel == 1 ? b1.sat       : b4.sat;
    assign busy_s = sel == 16 ? b16.busy      : sel == 1 ? b1.busy      : b4.busy;
    assign acc_s  = sel == 16 ? b16.acc_out   : sel == 1 ? b1.acc_out   : b4.acc_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Real-valued rules in integer units of 2^-8: bias*16, add each product, clamp to 19-bit signed range
    task automatic model(input int n, input logic [7:0] bv, output logic [18:0] e, output logic es);
        int a;
        a  = int'($signed(bv)) * 16;
        es = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = a + int'($signed(xs[i])) * int'($signed(ws[i]));
            if (a > 262143) begin a = 262143; es = 1'b1; end
            if (a < -262144) begin a = -262144; es = 1'b1; end
        end
        e = a[18:0];
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    // mode: 0 back-to-back, 1 fixed gap pattern, 2 random gaps; noise pulses start and scrambles bias while busy
    task automatic eval(input int n, input logic [7:0] bv, input int mode, input int stall, input bit noise, input string tag);
        logic [18:0] e;
        logic es;
        bit take;
        int i, c;
        model(n, bv, e, es);
        @(negedge clk); start = 1'b1; bias = bv;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        i = 0; c = 0;
        while (i < n && c < 1000) begin
            in_valid = mode == 0 ? 1'b1 : mode == 1 ? (c < 7 ? pat[6-c] : 1'b1) : ($urandom_range(0, 9) < 7);
            x_in = in_valid ? xs[i] : 8'($urandom);
            w_in = in_valid ? ws[i] : 8'($urandom);
            if (noise) begin start = c[0]; bias = 8'($urandom); end
            take = in_valid && rdy_s;
            @(posedge clk);
            if (take) i++;
            c++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk({tag, " beats"}, i, n);
        if (mode == 0) chk({tag, " latency"}, c, n);
        chk({tag, " out_valid"}, {31'b0, ov_s}, 1);
        chk({tag, " in_ready"}, {31'b0, rdy_s}, 0);
        chk({tag, " acc_out"}, {13'b0, acc_s}, {13'b0, e});
        chk({tag, " sat"}, {31'b0, sat_s}, {31'b0, es});
        for (int k = 0; k < stall; k++) begin
            out_ready = 1'b0; start = noise; bias = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            chk({tag, " stall valid"}, {31'b0, ov_s}, 1);
            chk({tag, " stall acc"}, {13'b0, acc_s}, {13'b0, e});
            chk({tag, " stall sat"}, {31'b0, sat_s}, {31'b0, es});
        end
        out_ready = 1'b1; start = noise;
        @(posedge clk);
        @(negedge clk); start = 1'b0; out_ready = 1'b0;
        chk({tag, " valid drop"}, {31'b0, ov_s}, 0);
        chk({tag, " idle"}, {31'b0, busy_s}, 0);
    endtask

    task automatic fill(input int n, input logic [7:0] xv, input logic [7:0] wv, input bit rnd);
        for (int i = 0; i < n; i++) begin
            xs[i] = rnd ? 8'($urandom) : xv;
            ws[i] = rnd ? 8'($urandom) : wv;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", {31'b0, rdy_s}, 0);
        chk("rst out_valid", {31'b0, ov_s}, 0);
        chk("rst busy", {31'b0, busy_s}, 0);
        chk("rst acc_out", {13'b0, acc_s}, 0);
        chk("rst sat", {31'b0, sat_s}, 0);
        rst = 1'b0;
        fill(4, 8'h10, 8'h20, 0);
        eval(4, 8'h10, 0, 0, 0, "basic");
        chk("basic const", {13'b0, b4.acc_out}, 32'h900);
        fill(4, 8'h18, 8'hE0, 0);
        eval(4, 8'hF0, 0, 0, 0, "neg");
        chk("neg const", {13'b0, b4.acc_out}, 32'h7F300);
        fill(4, 8'h10, 8'h20, 0);
        eval(4, 8'h10, 1, 5, 1, "stall");
        @(negedge clk); start = 1'b1; bias = 8'h10;
        @(posedge clk);
        @(negedge clk); start = 1'b0; in_valid = 1'b1; x_in = 8'h10; w_in = 8'h20;
        repeat (2) @(posedge clk);
        @(negedge clk); in_valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("abort in_ready", {31'b0, rdy_s}, 0);
        chk("abort busy", {31'b0, busy_s}, 0);
        chk("abort out_valid", {31'b0, ov_s}, 0);
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort quiet", {31'b0, ov_s}, 0);
        end
        in_valid = 1'b0;
        eval(4, 8'h10, 0, 0, 0, "after abort");
        for (int t = 0; t < 20; t++) begin
            fill(4, 8'h00, 8'h00, 1);
            eval(4, 8'($urandom), 2, $urandom_range(0, 3), 1'($urandom), "rand4");
        end
        do_reset();
        sel = 16;
        fill(16, 8'h80, 8'h80, 0);
        eval(16, 8'h00, 0, 0, 0, "sat");
        chk("sat const", {13'b0, b16.acc_out}, 32'h3FFFF);
        fill(16, 8'h00, 8'h00, 0);
        eval(16, 8'h00, 0, 0, 0, "sat clear");
        for (int t = 0; t < 6; t++) begin
            fill(16, 8'h00, 8'h00, 1);
            eval(16, 8'($urandom), 2, $urandom_range(0, 2), 1'($urandom), "rand16");
        end
        fill(16, 8'h81, 8'h7F, 0);
        eval(16, 8'h80, 2, 1, 0, "negsat");
        do_reset();
        sel = 1;
        xs[0] = 8'h40; ws[0] = 8'hC0;
        eval(1, 8'h08, 0, 0, 0, "min");
        chk("min const", {13'b0, b1.acc_out}, 32'h7F080);
        for (int t = 0; t < 6; t++) begin
            fill(1, 8'h00, 8'h00, 1);
            eval(1, 8'($urandom), 2, $urandom_range(0, 2), 1'($urandom), "rand1");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
